// File: rtl/vga_pkg.sv
// Shared definitions for the VGA refresh engine: test-pattern mode encodings,
// the colour-bar table and helpers that derive total line/frame lengths.
package vga_pkg;

    typedef enum logic [1:0] {
        MODE_PIXEL = 2'b00,
        MODE_BARS  = 2'b01,
        MODE_CHECK = 2'b10,
        MODE_GRAD  = 2'b11
    } mode_e;

    // Colour-bar table, left to right. Each bit is one channel {R,G,B},
    // and the channel is driven either all-ones or all-zeros.
    function automatic logic [2:0] bar_rgb(input logic [2:0] idx);
        case (idx)
            3'd0:    return 3'b000;  // black
            3'd1:    return 3'b111;  // white
            3'd2:    return 3'b100;  // red
            3'd3:    return 3'b110;  // yellow
            3'd4:    return 3'b010;  // green
            3'd5:    return 3'b011;  // cyan
            3'd6:    return 3'b001;  // blue
            default: return 3'b101;  // magenta
        endcase
    endfunction

    function automatic int h_total(input int act, input int fp, input int sync, input int bp);
        return act + fp + sync + bp;
    endfunction

    function automatic int v_total(input int act, input int fp, input int sync, input int bp);
        return act + fp + sync + bp;
    endfunction

endpackage

// File: rtl/vga_delay_line.sv
// Resettable fixed-depth shift register used to carry the request/sync/pattern
// bundle across the frame-buffer fetch latency.
module vga_delay_line #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 1
) (
    input  logic             clk,
    input  logic             rst_,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_stage [DEPTH];

    // Shift the bundle one stage per clock; reset empties every stage.
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_stage[i] <= '0;
            end
        end else begin
            r_stage[0] <= i_d;
            for (int i = 1; i < DEPTH; i++) begin
                r_stage[i] <= r_stage[i-1];
            end
        end
    end

    assign o_q = r_stage[DEPTH-1];

endmodule

// File: rtl/refresh_engine_param.sv
// Parametrised VGA refresh engine. Counters generate h/v timing and pixel
// requests; syncs and test patterns are delayed by the fetch latency so that
// returned pixel data, syncs, active_video and colour leave together.
module refresh_engine_param
    import vga_pkg::*;
#(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter bit HS_POL   = 1'b0,
    parameter bit VS_POL   = 1'b0,
    parameter int COLOR_W  = 4,
    parameter int PIX_LAT  = 2
) (
    input  logic                          clk,
    input  logic                          rst_,
    input  logic [1:0]                    test_mode,
    input  logic [3*COLOR_W-1:0]          pixel_data,
    input  logic                          pixel_valid,
    input  logic                          underflow_clr,
    output logic                          pix_req,
    output logic [$clog2(H_ACTIVE)-1:0]   pix_x,
    output logic [$clog2(V_ACTIVE)-1:0]   pix_y,
    output logic                          frame_start,
    output logic                          vga_h_sync,
    output logic                          vga_v_sync,
    output logic [COLOR_W-1:0]            vga_red,
    output logic [COLOR_W-1:0]            vga_green,
    output logic [COLOR_W-1:0]            vga_blue,
    output logic                          active_video,
    output logic                          underflow,
    output logic [15:0]                   frame_count
);

    localparam int XW      = $clog2(H_ACTIVE);
    localparam int YW      = $clog2(V_ACTIVE);
    localparam int H_TOTAL = h_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int V_TOTAL = v_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_TOTAL);
    localparam int CW      = 3 * COLOR_W;
    localparam int BW      = CW + 3;

    localparam logic [HW-1:0] H_LAST  = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_ACT   = HW'(H_ACTIVE);
    localparam logic [HW-1:0] H_SYN_S = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0] H_SYN_E = HW'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [VW-1:0] V_LAST  = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_ACT   = VW'(V_ACTIVE);
    localparam logic [VW-1:0] V_SYN_S = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0] V_SYN_E = VW'(V_ACTIVE + V_FP + V_SYNC - 1);
    localparam logic [XW-1:0] BAR_WX  = XW'(H_ACTIVE / 8);

    logic [HW-1:0]    r_h_cnt;
    logic [VW-1:0]    r_v_cnt;
    mode_e            r_mode_q;
    logic             r_seen_frame;
    logic [15:0]      r_frame_cnt;
    logic             r_underflow;

    logic             w_act_p0, w_hs_p0, w_vs_p0;
    logic [XW-1:0]    w_x_p0;
    logic [YW-1:0]    w_y_p0;
    mode_e            w_mode_p0;
    logic             w_x5, w_y5;
    logic [2:0]       w_bar_idx;
    logic [2:0]       w_bar_rgb;
    logic [CW-1:0]    w_pat_p0;
    logic [BW-1:0]    w_bundle_p0;

    logic [BW-1:0]    w_bundle_p1;
    logic             w_act_p1, w_hs_p1, w_vs_p1;
    logic [CW-1:0]    w_pat_p1;
    logic             w_underrun_p1;

    logic             r_act_p2, r_hs_p2, r_vs_p2;
    logic [CW-1:0]    r_rgb_p2;

    // Free-running raster counters: h wraps every line, v advances at line end.
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            r_h_cnt <= '0;
            r_v_cnt <= '0;
        end else if (r_h_cnt == H_LAST) begin
            r_h_cnt <= '0;
            r_v_cnt <= (r_v_cnt == V_LAST) ? '0 : r_v_cnt + VW'(1);
        end else begin
            r_h_cnt <= r_h_cnt + HW'(1);
        end
    end

    // ---- stage 0: decode directly from the counters ----
    assign w_act_p0    = (r_h_cnt < H_ACT) && (r_v_cnt < V_ACT);
    assign w_hs_p0     = (r_h_cnt >= H_SYN_S) && (r_h_cnt <= H_SYN_E);
    assign w_vs_p0     = (r_v_cnt >= V_SYN_S) && (r_v_cnt <= V_SYN_E);
    assign w_x_p0      = w_act_p0 ? r_h_cnt[XW-1:0] : '0;
    assign w_y_p0      = w_act_p0 ? r_v_cnt[YW-1:0] : '0;
    // Gated by reset so the pulse stays low while the counters are held at (0,0).
    assign frame_start = rst_ && (r_h_cnt == '0) && (r_v_cnt == '0);

    assign pix_req = w_act_p0;
    assign pix_x   = w_x_p0;
    assign pix_y   = w_y_p0;

    // The first pixel of a frame is generated in the same clock that latches
    // the new mode, so it must see the incoming mode rather than the old one.
    assign w_mode_p0 = frame_start ? mode_e'(test_mode) : r_mode_q;

    if (XW > 5) begin : g_x5
        assign w_x5 = w_x_p0[5];
    end else begin : g_x5_zero
        assign w_x5 = 1'b0;
    end

    if (YW > 5) begin : g_y5
        assign w_y5 = w_y_p0[5];
    end else begin : g_y5_zero
        assign w_y5 = 1'b0;
    end

    assign w_bar_idx = 3'(w_x_p0 / BAR_WX);
    assign w_bar_rgb = bar_rgb(w_bar_idx);

    // Test-pattern generator for the selected mode.
    always_comb begin
        w_pat_p0 = '0;
        case (w_mode_p0)
            MODE_BARS:  w_pat_p0 = {{COLOR_W{w_bar_rgb[2]}},
                                    {COLOR_W{w_bar_rgb[1]}},
                                    {COLOR_W{w_bar_rgb[0]}}};
            MODE_CHECK: w_pat_p0 = {CW{w_x5 ^ w_y5}};
            MODE_GRAD:  w_pat_p0 = {3{w_x_p0[XW-1 -: COLOR_W]}};
            default:    w_pat_p0 = '0;
        endcase
    end

    assign w_bundle_p0 = {w_act_p0, w_hs_p0, w_vs_p0, w_pat_p0};

    // ---- stage 1: bundle delayed to line up with returned pixel data ----
    vga_delay_line #(
        .WIDTH (BW),
        .DEPTH (PIX_LAT)
    ) u_delay (
        .clk  (clk),
        .rst_ (rst_),
        .i_d  (w_bundle_p0),
        .o_q  (w_bundle_p1)
    );

    assign w_act_p1      = w_bundle_p1[CW+2];
    assign w_hs_p1       = w_bundle_p1[CW+1];
    assign w_vs_p1       = w_bundle_p1[CW];
    assign w_pat_p1      = w_bundle_p1[CW-1:0];
    assign w_underrun_p1 = w_act_p1 && (r_mode_q == MODE_PIXEL) && !pixel_valid;

    // ---- stage 2: output registers driving the pins ----
    // Select colour source, blank outside active video, apply sync polarity.
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            r_act_p2 <= 1'b0;
            r_hs_p2  <= !HS_POL;
            r_vs_p2  <= !VS_POL;
            r_rgb_p2 <= '0;
        end else begin
            r_act_p2 <= w_act_p1;
            r_hs_p2  <= w_hs_p1 ? HS_POL : !HS_POL;
            r_vs_p2  <= w_vs_p1 ? VS_POL : !VS_POL;
            if (!w_act_p1) begin
                r_rgb_p2 <= '0;
            end else if (r_mode_q != MODE_PIXEL) begin
                r_rgb_p2 <= w_pat_p1;
            end else if (pixel_valid) begin
                r_rgb_p2 <= pixel_data;
            end else begin
                r_rgb_p2 <= '0;
            end
        end
    end

    // Latch the mode once per frame and count completed frames.
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            r_mode_q     <= MODE_PIXEL;
            r_seen_frame <= 1'b0;
            r_frame_cnt  <= '0;
        end else if (frame_start) begin
            r_mode_q     <= mode_e'(test_mode);
            r_seen_frame <= 1'b1;
            if (r_seen_frame) begin
                r_frame_cnt <= r_frame_cnt + 16'd1;
            end
        end
    end

    // Sticky underflow flag; a new underflow beats a simultaneous clear.
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            r_underflow <= 1'b0;
        end else if (w_underrun_p1) begin
            r_underflow <= 1'b1;
        end else if (underflow_clr) begin
            r_underflow <= 1'b0;
        end
    end

    assign active_video = r_act_p2;
    assign vga_h_sync   = r_hs_p2;
    assign vga_v_sync   = r_vs_p2;
    assign vga_red      = r_rgb_p2[CW-1 -: COLOR_W];
    assign vga_green    = r_rgb_p2[2*COLOR_W-1 -: COLOR_W];
    assign vga_blue     = r_rgb_p2[COLOR_W-1:0];
    assign underflow    = r_underflow;
    assign frame_count  = r_frame_cnt;

endmodule

// File: tb/tb_refresh_engine_param.sv
// Directed bench for refresh_engine_param: a reduced-size raster instance for
// frame-level behaviour, the small odd-timing instance, and a default instance
// for line-0 horizontal sync placement.
module tb_refresh_engine_param;

    localparam int HT  = 80;        // 64+4+8+4
    localparam int VT  = 46;        // 40+2+2+2
    localparam int FR  = HT * VT;   // clocks per frame
    localparam int LAT = 3;         // counters -> pins

    logic        clk;
    logic        rst_;
    logic [1:0]  test_mode;
    logic [11:0] pixel_data;
    logic        pixel_valid;
    logic        underflow_clr;

    // instance A (reduced raster)
    logic        a_req, a_fs, a_hs, a_vs, a_act, a_uf;
    logic [5:0]  a_x, a_y;
    logic [3:0]  a_r, a_g, a_b;
    logic [15:0] a_fc;
    logic [11:0] a_rgb;
    assign a_rgb = {a_r, a_g, a_b};

    // instance B (tiny raster, positive hsync, PIX_LAT 4)
    logic        b_req, b_fs, b_hs, b_vs, b_act, b_uf;
    logic [3:0]  b_x;
    logic [1:0]  b_y;
    logic [3:0]  b_r, b_g, b_b;
    logic [15:0] b_fc;

    // instance C (default timing)
    logic        c_req, c_fs, c_hs, c_vs, c_act, c_uf;
    logic [9:0]  c_x;
    logic [8:0]  c_y;
    logic [3:0]  c_r, c_g, c_b;
    logic [15:0] c_fc;

    refresh_engine_param #(
        .H_ACTIVE(64), .H_FP(4), .H_SYNC(8), .H_BP(4),
        .V_ACTIVE(40), .V_FP(2), .V_SYNC(2), .V_BP(2)
    ) u_dut_a (
        .clk(clk), .rst_(rst_), .test_mode(test_mode), .pixel_data(pixel_data),
        .pixel_valid(pixel_valid), .underflow_clr(underflow_clr),
        .pix_req(a_req), .pix_x(a_x), .pix_y(a_y), .frame_start(a_fs),
        .vga_h_sync(a_hs), .vga_v_sync(a_vs), .vga_red(a_r), .vga_green(a_g),
        .vga_blue(a_b), .active_video(a_act), .underflow(a_uf), .frame_count(a_fc)
    );

    refresh_engine_param #(
        .H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .HS_POL(1'b1), .PIX_LAT(4)
    ) u_dut_b (
        .clk(clk), .rst_(rst_), .test_mode(2'b00), .pixel_data(12'h5C3),
        .pixel_valid(1'b1), .underflow_clr(1'b0),
        .pix_req(b_req), .pix_x(b_x), .pix_y(b_y), .frame_start(b_fs),
        .vga_h_sync(b_hs), .vga_v_sync(b_vs), .vga_red(b_r), .vga_green(b_g),
        .vga_blue(b_b), .active_video(b_act), .underflow(b_uf), .frame_count(b_fc)
    );

    refresh_engine_param u_dut_c (
        .clk(clk), .rst_(rst_), .test_mode(2'b00), .pixel_data(12'h000),
        .pixel_valid(1'b1), .underflow_clr(1'b0),
        .pix_req(c_req), .pix_x(c_x), .pix_y(c_y), .frame_start(c_fs),
        .vga_h_sync(c_hs), .vga_v_sync(c_vs), .vga_red(c_r), .vga_green(c_g),
        .vga_blue(c_b), .active_video(c_act), .underflow(c_uf), .frame_count(c_fc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int drop_a = -1, drop_b = -1, clr_a = -1, clr_b = -1;

    // monitor accumulators for instances B and C
    bit mon_en = 1'b1;
    int c_low = 0, c_first = -1;
    int b_fs2 = -1, b_hs_hi = 0, b_act_n = 0, b_hs_first = -1, b_act_first = -1, b_misalign = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Fetch model: data returned in cycle cyc belongs to the request made 2 clocks earlier.
    task automatic drive_inputs();
        int r, h, v;
        r = cyc - 2;
        pixel_data = '0;
        if (r >= 0) begin
            h = r % HT;
            v = (r / HT) % VT;
            if (h < 64 && v < 40) pixel_data = {4'(h), 4'(v), 4'hA};
        end
        pixel_valid   = !(cyc == drop_a || cyc == drop_b);
        underflow_clr = (cyc == clr_a || cyc == clr_b);
    endtask

    task automatic monitor();
        if (mon_en) begin
            if (cyc < 800 && !c_hs) begin
                c_low++;
                if (c_first < 0) c_first = cyc;
            end
            if (b_fs && cyc > 0 && b_fs2 < 0) b_fs2 = cyc;
            if (cyc >= 5 && cyc < 173) begin
                if (b_hs)  b_hs_hi++;
                if (b_act) b_act_n++;
            end
            if (b_hs && b_hs_first < 0)   b_hs_first = cyc;
            if (b_act && b_act_first < 0) b_act_first = cyc;
            if (cyc < 400 && ({b_r, b_g, b_b} !== (b_act ? 12'h5C3 : 12'h000))) b_misalign++;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        drive_inputs();
        @(negedge clk);
        monitor();
    endtask

    task automatic run_until(input int c);
        while (cyc < c) tick();
    endtask

    // Advance to the cycle where pixel (x,y) of frame f is on the pins.
    task automatic goto_px(input int f, input int x, input int y);
        run_until(f * FR + y * HT + x + LAT);
    endtask

    task automatic release_reset();
        @(posedge clk);
        #1;
        rst_ = 1'b1;
        cyc  = 0;
        drive_inputs();
        @(negedge clk);
        monitor();
    endtask

    initial begin
        rst_ = 1'b0;
        test_mode = 2'b00;
        pixel_data = '0;
        pixel_valid = 1'b1;
        underflow_clr = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);

        chk("rst_active", a_act, 1'b0);
        chk("rst_rgb", a_rgb, 12'h000);
        chk("rst_hsync", a_hs, 1'b1);
        chk("rst_vsync", a_vs, 1'b1);
        chk("rst_fs", a_fs, 1'b0);
        chk("rst_fc", a_fc, 16'd0);
        chk("rst_uf", a_uf, 1'b0);
        chk("rst_req", a_req, 1'b1);
        chk("rst_b_hsync", b_hs, 1'b0);

        release_reset();
        chk("c0_fs", a_fs, 1'b1);
        chk("c0_x", a_x, 6'd0);

        // frame 0, pixel mode
        goto_px(0, 5, 3);   chk("f0_px5_3", a_rgb, 12'h53A);
                            chk("f0_act", a_act, 1'b1);
        goto_px(0, 64, 3);  chk("f0_blank_rgb", a_rgb, 12'h000);
                            chk("f0_blank_act", a_act, 1'b0);
        goto_px(0, 67, 3);  chk("hs_pre", a_hs, 1'b1);
        goto_px(0, 68, 3);  chk("hs_start", a_hs, 1'b0);
        goto_px(0, 75, 3);  chk("hs_end", a_hs, 1'b0);
        goto_px(0, 76, 3);  chk("hs_post", a_hs, 1'b1);
        goto_px(0, 0, 20);
        test_mode = 2'b10;
        goto_px(0, 5, 30);  chk("midframe_mode_ignored", a_rgb, 12'h5EA);
        chk("f0_fc", a_fc, 16'd0);
        goto_px(0, 0, 41);  chk("vs_pre", a_vs, 1'b1);
        goto_px(0, 0, 42);  chk("vs_start", a_vs, 1'b0);
        goto_px(0, 79, 43); chk("vs_end", a_vs, 1'b0);
        goto_px(0, 0, 44);  chk("vs_post", a_vs, 1'b1);

        // instances B and C have completed their measurement windows
        mon_en = 1'b0;
        chk("c_hs_first_low", c_first, 659);
        chk("c_hs_low_len", c_low, 96);
        chk("b_frame_len", b_fs2, 168);
        chk("b_hs_high_per_frame", b_hs_hi, 21);
        chk("b_hs_first_high", b_hs_first, 23);
        chk("b_active_per_frame", b_act_n, 64);
        chk("b_active_first", b_act_first, 5);
        chk("b_colour_align", b_misalign, 0);

        run_until(FR - 1);  chk("fs_before", a_fs, 1'b0);
        run_until(FR);      chk("fs_frame1", a_fs, 1'b1);

        // frame 1, checkerboard
        goto_px(1, 0, 0);   chk("f1_fc", a_fc, 16'd1);
        goto_px(1, 32, 0);  chk("chk_32_0", a_rgb, 12'hFFF);
        test_mode = 2'b01;
        goto_px(1, 0, 32);  chk("chk_0_32", a_rgb, 12'hFFF);
        goto_px(1, 32, 32); chk("chk_32_32", a_rgb, 12'h000);

        // frame 2, colour bars
        goto_px(2, 0, 1);   chk("bar_black", a_rgb, 12'h000);
        goto_px(2, 7, 1);   chk("bar_black_edge", a_rgb, 12'h000);
        goto_px(2, 8, 1);   chk("bar_white", a_rgb, 12'hFFF);
        goto_px(2, 16, 1);  chk("bar_red", a_rgb, 12'hF00);
        goto_px(2, 24, 1);  chk("bar_yellow", a_rgb, 12'hFF0);
        goto_px(2, 40, 1);  chk("bar_cyan", a_rgb, 12'h0FF);
        goto_px(2, 63, 1);  chk("bar_magenta", a_rgb, 12'hF0F);
        goto_px(2, 70, 1);  chk("bar_blank", a_rgb, 12'h000);
        test_mode = 2'b11;

        // frame 3, gradient
        goto_px(3, 20, 2);  chk("grad_20", a_rgb, 12'h555);
        goto_px(3, 63, 2);  chk("grad_63", a_rgb, 12'hFFF);
        test_mode = 2'b00;

        // frame 4, pixel mode with underflow events
        goto_px(4, 0, 1);   chk("f4_fc", a_fc, 16'd4);
        goto_px(4, 2, 1);   chk("f4_px2_1", a_rgb, 12'h21A);
        drop_a = 4 * FR + 5 * HT + 10 + 2;
        drop_b = 4 * FR + 5 * HT + 30 + 2;
        clr_a  = drop_b;
        clr_b  = 4 * FR + 5 * HT + 40 + 2;
        goto_px(4, 9, 5);   chk("uf_before", a_uf, 1'b0);
                            chk("f4_px9_5", a_rgb, 12'h95A);
        goto_px(4, 10, 5);  chk("uf_drop_rgb", a_rgb, 12'h000);
                            chk("uf_drop_act", a_act, 1'b1);
                            chk("uf_set", a_uf, 1'b1);
        goto_px(4, 20, 5);  chk("uf_sticky", a_uf, 1'b1);
        goto_px(4, 30, 5);  chk("uf_set_beats_clr", a_uf, 1'b1);
        goto_px(4, 40, 5);  chk("uf_cleared", a_uf, 1'b0);
                            chk("f4_px40_5", a_rgb, 12'h85A);

        // asynchronous reset in the middle of a line
        goto_px(4, 30, 20); chk("pre_rst_rgb", a_rgb, 12'hE4A);
        #1;
        rst_ = 1'b0;
        #1;
        chk("arst_active", a_act, 1'b0);
        chk("arst_rgb", a_rgb, 12'h000);
        chk("arst_hsync", a_hs, 1'b1);
        chk("arst_vsync", a_vs, 1'b1);
        chk("arst_fc", a_fc, 16'd0);
        chk("arst_x", a_x, 6'd0);
        drop_a = -1; drop_b = -1; clr_a = -1; clr_b = -1;
        @(posedge clk);
        release_reset();
        chk("rst2_fs", a_fs, 1'b1);
        chk("rst2_req", a_req, 1'b1);
        run_until(FR);      chk("rst2_fc_at_fs", a_fc, 16'd0);
                            chk("rst2_fs_frame1", a_fs, 1'b1);
        run_until(FR + 1);  chk("rst2_fc_after", a_fc, 16'd1);
        goto_px(1, 5, 3);   chk("rst2_px5_3", a_rgb, 12'h53A);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
